// File: rtl/cfg_bank_pkg.sv
// cfg_bank_pkg: stream control words, header field layout and FSM state encoding
// shared by the config bank top and its stream decoder.
package cfg_bank_pkg;

  localparam logic [15:0] SYNC_WORD   = 16'hF5A5;
  localparam logic [15:0] UNSYNC_WORD = 16'hFA5A;

  localparam logic [1:0] OP_WR = 2'b00;
  localparam logic [1:0] OP_RD = 2'b01;

  localparam int HDR_OP_MSB   = 15;
  localparam int HDR_OP_LSB   = 14;
  localparam int HDR_ADDR_MSB = 13;
  localparam int HDR_ADDR_LSB = 8;
  localparam int HDR_CNT_MSB  = 7;
  localparam int HDR_CNT_LSB  = 0;

  localparam int ADDR_W = HDR_ADDR_MSB - HDR_ADDR_LSB + 1;
  localparam int CNT_W  = HDR_CNT_MSB - HDR_CNT_LSB + 1;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_SYNC = 2'd1;
  localparam state_t ST_WR   = 2'd2;
  localparam state_t ST_RD   = 2'd3;

endpackage

// File: rtl/cfg_bank_fsm.sv
// cfg_bank_fsm: registers the host word stream, decodes sync/header words and
// walks the burst address/count for both write and readback bursts.
module cfg_bank_fsm
  import cfg_bank_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              wr_i,
  input  logic [DW-1:0]     data_i,
  input  logic              rd_ready_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [DW-1:0]     wr_data_o,
  output logic              commit_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic              rd_valid_o,
  output logic              busy_o
);

  logic              en_q;
  logic              wr_q;
  logic [DW-1:0]     data_q;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              taken;
  logic              is_sync;
  logic              is_unsync;
  logic [1:0]        hdr_op;
  logic [ADDR_W-1:0] hdr_addr;
  logic [CNT_W-1:0]  hdr_cnt;

  assign taken     = en_q & wr_q;
  assign is_sync   = taken && (data_q == SYNC_WORD);
  assign is_unsync = taken && (data_q == UNSYNC_WORD);
  assign hdr_op    = data_q[HDR_OP_MSB:HDR_OP_LSB];
  assign hdr_addr  = data_q[HDR_ADDR_MSB:HDR_ADDR_LSB];
  assign hdr_cnt   = data_q[HDR_CNT_MSB:HDR_CNT_LSB];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      en_q   <= 1'b0;
      wr_q   <= 1'b0;
      data_q <= '0;
    end else begin
      en_q   <= en_i;
      wr_q   <= wr_i;
      data_q <= data_i;
    end
  end

  // Inside WR every taken word is payload, so sync/unsync words are only escapes elsewhere.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (is_sync) state_d = ST_SYNC;
      end
      ST_SYNC: begin
        if (is_unsync) begin
          state_d = ST_IDLE;
        end else if (taken && (hdr_cnt != '0) && ((hdr_op == OP_WR) || (hdr_op == OP_RD))) begin
          state_d = (hdr_op == OP_WR) ? ST_WR : ST_RD;
          addr_d  = hdr_addr;
          cnt_d   = hdr_cnt;
        end
      end
      ST_WR: begin
        if (taken) begin
          addr_d = addr_q + ADDR_W'(1);
          cnt_d  = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = ST_SYNC;
        end
      end
      ST_RD: begin
        if (is_unsync) begin
          state_d = ST_IDLE;
        end else if (rd_ready_i) begin
          addr_d = addr_q + ADDR_W'(1);
          cnt_d  = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = ST_SYNC;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign wr_en_o    = (state_q == ST_WR) && taken;
  assign wr_addr_o  = addr_q;
  assign wr_data_o  = data_q;
  assign commit_o   = (state_q == ST_SYNC) && is_unsync;
  assign rd_addr_o  = addr_q;
  assign rd_valid_o = (state_q == ST_RD);
  assign busy_o     = (state_q == ST_WR) || (state_q == ST_RD);

endmodule

// File: rtl/cfg_bank.sv
// cfg_bank: NUM_REGS x DW config register bank fed by the USB word stream, with
// write strobes, self-clearing pulse bits and burst readback. Option: CFG_BANK_SHADOW_EN.
module cfg_bank
  import cfg_bank_pkg::*;
#(
  parameter int                         NUM_REGS   = 16,
  parameter int                         DW         = 16,
  parameter logic [NUM_REGS*DW-1:0]     RST_VEC    = '0,
  parameter logic [NUM_REGS*DW-1:0]     PULSE_MASK = '0
) (
  input  logic                   usb_clk,
  input  logic                   usb_rst_n,
  input  logic                   usb_en,
  input  logic                   usb_wr,
  input  logic [DW-1:0]          usb_data,
  output logic [NUM_REGS*DW-1:0] cfg_bus,
  output logic [NUM_REGS-1:0]    cfg_wr_pulse,
  output logic                   rd_valid,
  output logic [DW-1:0]          rd_data,
  input  logic                   rd_ready,
  output logic                   busy
);

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DW-1:0]     wr_data;
  logic              commit;
  logic [ADDR_W-1:0] rd_addr;

  logic [NUM_REGS*DW-1:0] act_q, act_d;
  logic [NUM_REGS-1:0]    pulse_q, pulse_d;
  logic [NUM_REGS-1:0]    wr_hit;
  logic [NUM_REGS*DW-1:0] rd_src;
  logic [DW-1:0]          rd_word;

  cfg_bank_fsm #(.DW(DW)) u_fsm (
    .clk_i      (usb_clk),
    .rst_ni     (usb_rst_n),
    .en_i       (usb_en),
    .wr_i       (usb_wr),
    .data_i     (usb_data),
    .rd_ready_i (rd_ready),
    .wr_en_o    (wr_en),
    .wr_addr_o  (wr_addr),
    .wr_data_o  (wr_data),
    .commit_o   (commit),
    .rd_addr_o  (rd_addr),
    .rd_valid_o (rd_valid),
    .busy_o     (busy)
  );

  // Addresses at or beyond NUM_REGS match no slot, which silently drops the write.
  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      wr_hit[i] = wr_en && (wr_addr == ADDR_W'(i));
    end
  end

`ifdef CFG_BANK_SHADOW_EN
  logic [NUM_REGS*DW-1:0] shadow_q;
  logic [NUM_REGS-1:0]    dirty_q;

  always_ff @(posedge usb_clk or negedge usb_rst_n) begin
    if (!usb_rst_n) begin
      shadow_q <= RST_VEC;
      dirty_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_hit[i]) begin
          shadow_q[i*DW +: DW] <= wr_data;
          dirty_q[i]           <= 1'b1;
        end else if (commit) begin
          dirty_q[i]           <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    act_d = act_q & ~PULSE_MASK;
    if (commit) act_d = shadow_q;
    pulse_d = commit ? dirty_q : '0;
  end

  assign rd_src = shadow_q;
`else
  logic unused_commit;
  assign unused_commit = commit;

  always_comb begin
    act_d = act_q & ~PULSE_MASK;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_hit[i]) act_d[i*DW +: DW] = wr_data;
    end
    pulse_d = wr_hit;
  end

  assign rd_src = act_q;
`endif

  always_ff @(posedge usb_clk or negedge usb_rst_n) begin
    if (!usb_rst_n) begin
      act_q   <= RST_VEC;
      pulse_q <= '0;
    end else begin
      act_q   <= act_d;
      pulse_q <= pulse_d;
    end
  end

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_addr == ADDR_W'(i)) rd_word = rd_src[i*DW +: DW];
    end
  end

  assign cfg_bus      = act_q;
  assign cfg_wr_pulse = pulse_q;
  assign rd_data      = rd_valid ? rd_word : '0;

endmodule

// File: tb/tb_cfg_bank.sv
// tb_cfg_bank: directed-vector bench for cfg_bank (default build, 16 registers,
// reg1 reset to 1, reg12 bit 15 self-clearing).
module tb_cfg_bank;

  localparam int NUM_REGS = 16;
  localparam int DW       = 16;
  localparam logic [255:0] RST_VEC    = 256'h1 << 16;
  localparam logic [255:0] PULSE_MASK = 256'h1 << 207;

  logic          usb_clk;
  logic          usb_rst_n;
  logic          usb_en;
  logic          usb_wr;
  logic [15:0]   usb_data;
  logic [255:0]  cfg_bus;
  logic [15:0]   cfg_wr_pulse;
  logic          rd_valid;
  logic [15:0]   rd_data;
  logic          rd_ready;
  logic          busy;

  int assertCount = 0;
  int failCount   = 0;
  logic [255:0] expBus;

  cfg_bank #(
    .NUM_REGS   (NUM_REGS),
    .DW         (DW),
    .RST_VEC    (RST_VEC),
    .PULSE_MASK (PULSE_MASK)
  ) dut (
    .usb_clk      (usb_clk),
    .usb_rst_n    (usb_rst_n),
    .usb_en       (usb_en),
    .usb_wr       (usb_wr),
    .usb_data     (usb_data),
    .cfg_bus      (cfg_bus),
    .cfg_wr_pulse (cfg_wr_pulse),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .rd_ready     (rd_ready),
    .busy         (busy)
  );

  initial usb_clk = 1'b0;
  always #5 usb_clk = ~usb_clk;

  task automatic checkOutput(input string tag, input logic [255:0] actual, input logic [255:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Drives one input word, then returns 1ns after the edge that registers it.
  task automatic applyStimulus(input logic en, input logic wr, input logic [15:0] d);
    usb_en   = en;
    usb_wr   = wr;
    usb_data = d;
    @(posedge usb_clk);
    #1;
  endtask

  task automatic sendWord(input logic [15:0] d);
    applyStimulus(1'b1, 1'b1, d);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 16'h0000);
  endtask

  function automatic logic [15:0] regOf(input int i);
    return cfg_bus[i*16 +: 16];
  endfunction

  initial begin
    usb_rst_n = 1'b0;
    usb_en    = 1'b0;
    usb_wr    = 1'b0;
    usb_data  = '0;
    rd_ready  = 1'b0;
    expBus    = RST_VEC;
    #12;
    checkOutput("reset_bus", cfg_bus, RST_VEC);
    checkOutput("reset_reg1", 256'(regOf(1)), 256'h0001);
    checkOutput("reset_rd_valid", 256'(rd_valid), 256'h0);
    checkOutput("reset_rd_data", 256'(rd_data), 256'h0);
    checkOutput("reset_pulse", 256'(cfg_wr_pulse), 256'h0);
    checkOutput("reset_busy", 256'(busy), 256'h0);
    @(negedge usb_clk);
    usb_rst_n = 1'b1;
    @(posedge usb_clk);
    #1;

    // en without wr is not taken, so the header/data that follow are ignored
    applyStimulus(1'b1, 1'b0, 16'hF5A5);
    sendWord(16'h0002);
    sendWord(16'h7777);
    idleCycle();
    idleCycle();
    checkOutput("nowr_bus", cfg_bus, expBus);
    checkOutput("nowr_busy", 256'(busy), 256'h0);

    // write burst to regs 3..5
    sendWord(16'hF5A5);
    sendWord(16'h0303);
    sendWord(16'h1111);
    checkOutput("wr_busy", 256'(busy), 256'h1);
    sendWord(16'h2222);
    checkOutput("wr_reg3", 256'(regOf(3)), 256'h1111);
    checkOutput("wr_pulse3", 256'(cfg_wr_pulse), 256'h0008);
    sendWord(16'h3333);
    checkOutput("wr_reg4", 256'(regOf(4)), 256'h2222);
    checkOutput("wr_pulse4", 256'(cfg_wr_pulse), 256'h0010);
    idleCycle();
    checkOutput("wr_reg5", 256'(regOf(5)), 256'h3333);
    checkOutput("wr_pulse5", 256'(cfg_wr_pulse), 256'h0020);
    checkOutput("wr_done_busy", 256'(busy), 256'h0);
    idleCycle();
    checkOutput("wr_pulse_clear", 256'(cfg_wr_pulse), 256'h0);
    expBus[3*16 +: 16] = 16'h1111;
    expBus[4*16 +: 16] = 16'h2222;
    expBus[5*16 +: 16] = 16'h3333;
    checkOutput("wr_bus", cfg_bus, expBus);

    // read burst with a 5-cycle stall
    sendWord(16'h4302);
    checkOutput("rd_not_yet", 256'(rd_valid), 256'h0);
    idleCycle();
    for (int k = 0; k < 5; k++) begin
      checkOutput("rd_stall_valid", 256'(rd_valid), 256'h1);
      checkOutput("rd_stall_data", 256'(rd_data), 256'h1111);
      idleCycle();
    end
    rd_ready = 1'b1;
    idleCycle();
    checkOutput("rd_second_valid", 256'(rd_valid), 256'h1);
    checkOutput("rd_second_data", 256'(rd_data), 256'h2222);
    idleCycle();
    checkOutput("rd_end_valid", 256'(rd_valid), 256'h0);
    checkOutput("rd_end_busy", 256'(busy), 256'h0);
    rd_ready = 1'b0;

    // out-of-range write and readback around the top of the bank
    sendWord(16'h0F02);
    sendWord(16'hAAAA);
    sendWord(16'hBBBB);
    idleCycle();
    idleCycle();
    expBus[15*16 +: 16] = 16'hAAAA;
    checkOutput("oor_bus", cfg_bus, expBus);
    sendWord(16'h4F02);
    idleCycle();
    checkOutput("oor_rd15", 256'(rd_data), 256'hAAAA);
    rd_ready = 1'b1;
    idleCycle();
    checkOutput("oor_rd16_valid", 256'(rd_valid), 256'h1);
    checkOutput("oor_rd16_data", 256'(rd_data), 256'h0);
    idleCycle();
    checkOutput("oor_rd_end", 256'(rd_valid), 256'h0);
    rd_ready = 1'b0;

    // self-clearing bit reg12[15]
    sendWord(16'h0C01);
    sendWord(16'h8000);
    idleCycle();
    checkOutput("pulse_bit_high", 256'(regOf(12)), 256'h8000);
    checkOutput("pulse_strobe12", 256'(cfg_wr_pulse), 256'h1000);
    idleCycle();
    checkOutput("pulse_bit_clear", 256'(regOf(12)), 256'h0);

    // FA5A inside a write burst is data, and the stream stays synced
    sendWord(16'h0001);
    sendWord(16'hFA5A);
    idleCycle();
    expBus[0 +: 16] = 16'hFA5A;
    checkOutput("fa5a_data_bus", cfg_bus, expBus);
    sendWord(16'h4001);
    idleCycle();
    checkOutput("fa5a_synced_valid", 256'(rd_valid), 256'h1);
    checkOutput("fa5a_synced_data", 256'(rd_data), 256'hFA5A);
    rd_ready = 1'b1;
    idleCycle();
    rd_ready = 1'b0;

    // abort wins over a simultaneous accept and returns to IDLE
    sendWord(16'h4302);
    idleCycle();
    checkOutput("abort_pre_data", 256'(rd_data), 256'h1111);
    sendWord(16'hFA5A);
    checkOutput("abort_pre_valid", 256'(rd_valid), 256'h1);
    rd_ready = 1'b1;
    idleCycle();
    rd_ready = 1'b0;
    checkOutput("abort_valid", 256'(rd_valid), 256'h0);
    checkOutput("abort_busy", 256'(busy), 256'h0);
    sendWord(16'h4302);
    idleCycle();
    idleCycle();
    checkOutput("abort_idle", 256'(rd_valid), 256'h0);

    // reset in the middle of a write burst
    sendWord(16'hF5A5);
    sendWord(16'h0002);
    sendWord(16'h5555);
    #2 usb_rst_n = 1'b0;
    #1;
    checkOutput("rst_wr_bus", cfg_bus, RST_VEC);
    checkOutput("rst_wr_busy", 256'(busy), 256'h0);
    checkOutput("rst_wr_pulse", 256'(cfg_wr_pulse), 256'h0);
    #1 usb_rst_n = 1'b1;
    @(posedge usb_clk);
    #1;
    sendWord(16'h6666);
    sendWord(16'h7777);
    idleCycle();
    idleCycle();
    checkOutput("rst_wr_ignored", cfg_bus, RST_VEC);

    // reset during a stalled read
    sendWord(16'hF5A5);
    sendWord(16'h4102);
    idleCycle();
    checkOutput("rst_rd_pre", 256'(rd_data), 256'h0001);
    #2 usb_rst_n = 1'b0;
    #1;
    checkOutput("rst_rd_valid", 256'(rd_valid), 256'h0);
    checkOutput("rst_rd_data", 256'(rd_data), 256'h0);
    #1 usb_rst_n = 1'b1;
    @(posedge usb_clk);
    #1;
    sendWord(16'h4102);
    idleCycle();
    idleCycle();
    checkOutput("rst_rd_ignored", 256'(rd_valid), 256'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/cfg_bank.md
Name: cfg_bank

Overview:
- Parametrised successor to the fixed 14-register USB config block.
- Decodes the host configuration word stream on usb_clk into a NUM_REGS x DW register bank.
- Drives the flat register bus into capture, trigger and SD logic.
- Adds burst readback with a valid/ready handshake, per-register write strobes and parametrised self-clearing (pulse) bits.

Parameters:
- NUM_REGS, 16, number of config registers; 1..64.
- DW, 16, register and stream word width; fixed at 16 for this stream format; other values are out of scope.
- RST_VEC, {NUM_REGS*DW{1'b0}}, flat reset value; register i reset value = RST_VEC[i*DW +: DW].
- PULSE_MASK, {NUM_REGS*DW{1'b0}}, set bits self-clear one cycle after being written 1.

Ports:
- usb_clk  in  1  sole clock.
- usb_rst_n  in  1  asynchronous active-low reset.
- usb_en  in  1  stream word enable.
- usb_wr  in  1  stream write qualifier; a word is taken only when usb_en & usb_wr.
- usb_data  in  DW  stream word.
- cfg_bus  out  NUM_REGS*DW  active register contents; register i at [i*DW +: DW].
- cfg_wr_pulse  out  NUM_REGS  one-cycle strobe per register, high the cycle after that register is written.
- rd_valid  out  1  readback word valid.
- rd_data  out  DW  readback word.
- rd_ready  in  1  readback consumer ready.
- busy  out  1  high in WR or RD state.

Behaviour:
Input stage:
- usb_en, usb_wr and usb_data are registered once. All decode uses the registered copies.
- Only words with en & wr are "taken".

State machine, 4 states: IDLE, SYNC, WR, RD.
- IDLE:
  - taken 16'hF5A5 -> SYNC.
  - Everything else ignored.
- SYNC:
  - taken 16'hFA5A -> IDLE.
  - Taken header [15:14]=00 with [7:0]!=0 -> WR; addr<=[13:8], cnt<=[7:0].
  - Taken header [15:14]=01 with [7:0]!=0 -> RD; addr and cnt loaded the same way.
  - Header with count 0, opcode 10/11, or any other word: ignored, stay in SYNC.
- WR:
  - Every taken word is data; F5A5/FA5A are not escapes here.
  - Each word writes reg[addr] if addr<NUM_REGS; out-of-range writes are dropped silently.
  - addr increments (6-bit wrap 63->0); cnt decrements.
  - cnt reaching 0 -> SYNC.
- RD:
  - rd_valid=1; rd_data = reg[addr], or 0 if addr>=NUM_REGS.
  - On rd_valid & rd_ready: addr++, cnt--; at cnt==0, rd_valid drops next cycle and state -> SYNC.
  - rd_data is held stable while rd_valid & ~rd_ready.
  - Taken FA5A in RD aborts: rd_valid low next cycle, state -> IDLE. Abort wins over a simultaneous rd_ready.
  - All other taken words in RD are ignored.

Latency:
- Word taken at input edge N is registered at edge N.
- The register updates and cfg_wr_pulse[i] asserts at edge N+1; both are visible after N+1.
- Back-to-back words every cycle are supported with no stalls in WR.

Pulse bits:
- A bit in PULSE_MASK written 1 reads 1 for exactly one cycle, then clears.
- A new write of 1 in that same cycle keeps it 1 for one more cycle.

Reset:
- Asynchronous on usb_rst_n low, including mid-burst:
  - state=IDLE, addr=0, cnt=0.
  - regs=RST_VEC, cfg_wr_pulse=0, rd_valid=0, rd_data=0, busy=0, input stage=0.

Optional Feature:
- Macro CFG_BANK_SHADOW_EN.
- Defined:
  - WR bursts write a shadow bank; cfg_bus shows the active bank.
  - A taken FA5A in SYNC copies shadow->active in one cycle and pulses cfg_wr_pulse for every register written since the last commit.
  - Readback returns shadow contents.
- Undefined:
  - No shadow; writes go directly to active as described above.

Decomposition:
- Package cfg_bank_pkg holds:
  - SYNC_WORD=16'hF5A5 and UNSYNC_WORD=16'hFA5A.
  - Opcodes OP_WR=2'b00 and OP_RD=2'b01.
  - Header field positions.
  - State encoding (IDLE/SYNC/WR/RD).
- One sub-module, cfg_bank_fsm: input stage, header decode, addr/cnt counters and read handshake.
  - Outputs a write-enable/addr/data triple and a read addr to the top.
  - The top holds the register array, pulse logic and shadow.

Test Plan:
1. Reset with RST_VEC reg1=1 -> cfg_bus reg1=16'h0001, all else 0, rd_valid=0.
2. Write burst: F5A5, 16'h0303, 1111, 2222, 3333 -> regs3..5 = 1111/2222/3333 two edges after each word; cfg_wr_pulse bits 3,4,5 each single-cycle; state returns to SYNC.
3. Read burst: F5A5, 16'h4302 with rd_ready low 5 cycles then high -> rd_data=1111 held stable, then 2222 on next accept; rd_valid deasserts after 2nd accept.
4. Out-of-range (NUM_REGS=16): header 16'h0F02 writes AAAA, BBBB -> reg15=AAAA, BBBB dropped; readback of addr 16 returns 0.
5. PULSE_MASK bit reg12[15]: write 16'h8000 to reg12 -> bit high one cycle then 0; write FA5A as WR data word -> stored as data, stays synced.
6. usb_rst_n low mid-WR burst and mid-RD stall -> immediate IDLE, rd_valid=0, regs=RST_VEC; following data words ignored until F5A5.
